// File: rtl/fsm_alu_pkg.sv
// ============================================================
// fsm_alu_pkg : opcode/state types and widths for fsm_alu
// Rev 1.0
// ============================================================
`default_nettype none

package fsm_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5,
    OP_MUL  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fsm_alu_if.sv
// ============================================================
// fsm_alu_if : request/result valid-ready bundle for fsm_alu
// Rev 1.0
// ============================================================
`default_nettype none

interface fsm_alu_if
  import fsm_alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_s;
  logic [WIDTH-1:0]  out_hi;
  logic              out_carry;
  logic              out_ovf;
  logic              out_zero;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_s, out_hi, out_carry, out_ovf, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_s, out_hi, out_carry, out_ovf, out_zero, out_err
  );

endinterface

`default_nettype wire

// File: rtl/fsm_alu_mul.sv
// ============================================================
// fsm_alu_mul : iterative shift-add WIDTHxWIDTH unsigned multiplier
// Rev 1.0
// ============================================================
`default_nettype none

module fsm_alu_mul #(
  parameter int WIDTH = 8
) (
  input  wire logic                 sys_clk,
  input  wire logic                 sys_rst_n,
  input  wire logic                 i_start,
  input  wire logic [WIDTH-1:0]     i_a,
  input  wire logic [WIDTH-1:0]     i_b,
  output logic                      o_done,
  output logic [2*WIDTH-1:0]        o_prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod_next;

  // Low half starts as the multiplier and is shifted out as product bits shift in.
  assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};

  assign o_done = r_busy && (r_cnt == C_LAST);
  assign o_prod = w_prod_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
    end else if (r_busy) begin
      r_prod <= w_prod_next;
      r_cnt  <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fsm_alu.sv
// ============================================================
// fsm_alu : handshaked ALU sequencer; FSM_ALU_MUL_EN enables MUL
// Rev 1.0
// ============================================================
`default_nettype none

module fsm_alu
  import fsm_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic  sys_clk,
  input  wire logic  sys_rst_n,
  fsm_alu_if.slave   bus
);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_s;
  logic              r_carry;
  logic              r_ovf;
  logic              r_zero;
  logic              r_err;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic [WIDTH:0]    w_add;
  logic [WIDTH:0]    w_sub;
  logic [WIDTH-1:0]  w_alu_s;
  logic              w_alu_c;
  logic              w_alu_v;
  logic              w_alu_err;

  assign w_accept = bus.in_valid && w_in_ready;

`ifdef FSM_ALU_MUL_EN
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*WIDTH-1:0]  w_mul_prod;
  logic [WIDTH-1:0]    r_hi;

  // Multiplier takes operands straight from the bus on the acceptance edge.
  assign w_mul_start = w_accept && (bus.in_op == OP_MUL);

  fsm_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_start   (w_mul_start),
    .i_a       (bus.in_a),
    .i_b       (bus.in_b),
    .o_done    (w_mul_done),
    .o_prod    (w_mul_prod)
  );

  assign bus.out_hi = r_hi;
`else
  assign bus.out_hi = '0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
`ifdef FSM_ALU_MUL_EN
          w_next = (bus.in_op == OP_MUL) ? ST_MUL : ST_EXEC;
`else
          w_next = ST_EXEC;
`endif
        end
      end
      ST_EXEC: w_next = ST_DONE;
      ST_MUL: begin
`ifdef FSM_ALU_MUL_EN
        if (w_mul_done) begin
          w_next = ST_DONE;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == ST_IDLE);
    w_out_valid = (r_state == ST_DONE);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_alu_s   = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_err = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_s = w_add[WIDTH-1:0];
        w_alu_c = w_add[WIDTH];
        w_alu_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_s = w_sub[WIDTH-1:0];
        w_alu_c = w_sub[WIDTH];
        w_alu_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_alu_s = r_a & r_b;
      OP_OR:   w_alu_s = r_a | r_b;
      OP_XOR:  w_alu_s = r_a ^ r_b;
      OP_PASS: w_alu_s = r_a;
      default: w_alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
`ifdef FSM_ALU_MUL_EN
      r_hi    <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op <= op_e'(bus.in_op);
        r_a  <= bus.in_a;
        r_b  <= bus.in_b;
      end
      if (r_state == ST_EXEC) begin
        r_s     <= w_alu_s;
        r_carry <= w_alu_c;
        r_ovf   <= w_alu_v;
        r_zero  <= !w_alu_err && (w_alu_s == '0);
        r_err   <= w_alu_err;
`ifdef FSM_ALU_MUL_EN
        r_hi    <= '0;
      end else if ((r_state == ST_MUL) && w_mul_done) begin
        r_s     <= w_mul_prod[WIDTH-1:0];
        r_hi    <= w_mul_prod[2*WIDTH-1:WIDTH];
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_zero  <= (w_mul_prod == '0);
        r_err   <= 1'b0;
`endif
      end
    end
  end

  assign bus.out_s     = r_s;
  assign bus.out_carry = r_carry;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_zero  = r_zero;
  assign bus.out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fsm_alu.sv
// ============================================================
// tb_fsm_alu : randomized self-checking bench for fsm_alu
// Rev 1.0
// ============================================================
`default_nettype none

module tb_fsm_alu;

  localparam int W = 8;
`ifdef FSM_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  fsm_alu_if #(.WIDTH(W)) bus ();

  fsm_alu #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model from the arithmetic definitions (signed view via integer range).
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] s, output logic [W-1:0] hi,
                                output logic c, output logic v, output logic z, output logic e);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    s = '0; hi = '0; c = 1'b0; v = 1'b0; z = 1'b0; e = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; sr = sa + sb; s = W'(r); c = (r >= 2**W);
                  v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1))); z = (s == 0); end
      3'd1: begin r = ua - ub; sr = sa - sb; s = W'(r); c = (ua < ub);
                  v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1))); z = (s == 0); end
      3'd2: begin s = a & b; z = (s == 0); end
      3'd3: begin s = a | b; z = (s == 0); end
      3'd4: begin s = a ^ b; z = (s == 0); end
      3'd5: begin s = a;     z = (s == 0); end
      3'd6: begin
        if (MUL_EN) begin
          r = ua * ub; s = W'(r); hi = W'(r / (2**W)); z = (r == 0);
        end else begin
          e = 1'b1;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] es, ehi;
    logic ec, ev, ez, ee;
    int lat, exp_lat;
    bit seen;
    model(op, a, b, es, ehi, ec, ev, ez, ee);
    exp_lat = (op == 3'd6 && MUL_EN) ? W : 1;
    @(negedge sys_clk);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready op=%0d: in_ready=%b required 1", op, bus.in_ready);
    end
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0; bus.in_a = W'($urandom); bus.in_b = W'($urandom); bus.in_op = 3'($urandom);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL busy_ready op=%0d: in_ready=%b required 0", op, bus.in_ready);
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < W + 4) begin
      @(posedge sys_clk); #1;
      lat++;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++; $display("FAIL latency op=%0d: seen=%b cycles=%0d required %0d", op, seen, lat, exp_lat);
    end
    checks++;
    if ({bus.out_s, bus.out_hi, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_err}
        !== {es, ehi, ec, ev, ez, ee}) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: s=%h hi=%h c=%b v=%b z=%b e=%b required s=%h hi=%h c=%b v=%b z=%b e=%b",
               op, a, b, bus.out_s, bus.out_hi, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_err,
               es, ehi, ec, ev, ez, ee);
    end
    bus.out_ready = 1'b1;
    @(posedge sys_clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_s !== es) begin
      errors++;
      $display("FAIL handshake op=%0d: out_valid=%b in_ready=%b out_s=%h required 0 1 %h",
               op, bus.out_valid, bus.in_ready, bus.out_s, es);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_s, bus.out_hi, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_err}
        !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 4'b0}) begin
      errors++; $display("FAIL reset_state: in_ready=%b out_valid=%b out_s=%h required 1 0 00",
                         bus.in_ready, bus.out_valid, bus.out_s);
    end
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 8'h05, 8'h02);
    do_op(3'd1, 8'h02, 8'h05);
    do_op(3'd1, 8'h80, 8'h01);
    do_op(3'd0, 8'hFF, 8'h01);
    do_op(3'd0, 8'h7F, 8'h01);
    do_op(3'd6, 8'h12, 8'h34);
    do_op(3'd7, 8'h12, 8'h34);
    do_op(3'd6, 8'h00, 8'hA5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_backpressure();
    @(negedge sys_clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 8'h33; bus.in_b = 8'h11;
    @(posedge sys_clk); #1;
    bus.in_op = 3'd1; bus.in_a = 8'hEE; bus.in_b = 8'h01;
    @(posedge sys_clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_s !== 8'h44 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d: out_valid=%b out_s=%h in_ready=%b required 1 44 0",
                           i, bus.out_valid, bus.out_s, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge sys_clk); #1;
    bus.out_ready = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_s !== 8'h44) begin
      errors++; $display("FAIL release: out_valid=%b in_ready=%b out_s=%h required 0 1 44",
                         bus.out_valid, bus.in_ready, bus.out_s);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    logic [W-1:0] a, b, exp_s;
    a = W'($urandom); b = W'($urandom);
    exp_s = W'(int'(a) + int'(b));
    n_valid = 0;
    @(negedge sys_clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = a; bus.in_b = b; bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge sys_clk); #1;
      if (bus.out_valid === 1'b1) begin
        n_valid++;
        checks++;
        if (bus.out_s !== exp_s) begin
          errors++; $display("FAIL b2b_result: out_s=%h required %h", bus.out_s, exp_s);
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge sys_clk); #1;
    bus.out_ready = 1'b0;
    @(posedge sys_clk); #1;
    checks++;
    if (n_valid != 4) begin
      errors++; $display("FAIL b2b_throughput: results=%0d required 4", n_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    do_op(3'd0, 8'h40, 8'h41);
    @(negedge sys_clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd6; bus.in_a = 8'h12; bus.in_b = 8'h34;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_s, bus.out_hi, bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_err}
        !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}, 4'b0}) begin
      errors++; $display("FAIL midreset_clear: out_valid=%b in_ready=%b out_s=%h out_hi=%h required 0 1 00 00",
                         bus.out_valid, bus.in_ready, bus.out_s, bus.out_hi);
    end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    do_op(3'd0, 8'h01, 8'h01);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_alu.md
# fsm_alu

Parametrised, handshaked arithmetic/logic sequencer; next generation of our fixed 8-bit add/sub FSM. It accepts an operand pair and opcode over a valid/ready input port, executes in a small state machine, and presents a registered result with flags on a valid/ready output port. Unlike its predecessor it returns to idle after each result, so it serves repeated requests. It sits between a CSR/command front-end and any consumer of computed values.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- sys_clk  in  1  single clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A, 6 MUL, 7 reserved
- in_a  in  WIDTH  operand A (unsigned; signed view used for overflow only)
- in_b  in  WIDTH  operand B
- out_valid  out  1  result present (high only in DONE)
- out_ready  in  1  consumer takes result
- out_s  out  WIDTH  result (MUL: low half of product)
- out_hi  out  WIDTH  MUL high half; 0 for all other ops
- out_carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); 0 otherwise
- out_ovf  out  1  signed overflow for ADD/SUB; 0 otherwise
- out_zero  out  1  out_s == 0 (and out_hi == 0 for MUL)
- out_err  out  1  opcode illegal in this build; out_s/out_hi/flags then 0

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: in_ready=1. On in_valid, latch in_a, in_b, in_op; go EXEC (op 0–5, 7, or 6 without macro) or MUL (op 6 with macro). in_valid low: stay.
- EXEC: compute combinationally from latched operands, register out_s and all flags, go DONE.
- MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles; on last iteration register out_s/out_hi/flags, go DONE.
- DONE: out_valid=1. On out_ready go IDLE; otherwise hold, outputs stable.
- Arithmetic: ADD/SUB computed in WIDTH+1 bits; out_s = low WIDTH bits, wrap-around modulo 2^WIDTH. ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
- Result registers retain last value after leaving DONE until the next result is registered; only out_valid qualifies them.
- in_a/in_b/in_op changes outside IDLE acceptance are ignored.
- Reset (any state, including mid-MUL): state IDLE, all result/flag outputs 0, out_valid 0, in_ready 1 from the first cycle after release; partial MUL discarded.

## Timing
- Acceptance at edge N (in_valid & in_ready).
- ALU ops: out_valid rises at edge N+1 (IDLE→EXEC at N, EXEC→DONE at N+1).
- MUL: out_valid rises at edge N+WIDTH.
- Handshake out at edge M (out_valid & out_ready): IDLE after M, in_ready high in cycle after M; next acceptance earliest at M+1. Max throughput one ALU op per 3 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; both are state decodes.

## Configuration
- FSM_ALU_MUL_EN defined: opcode 6 runs the iterative multiplier, MUL state and sub-module present.
- Undefined: opcode 6 treated like 7 — EXEC, out_err=1, out_s=out_hi=0, flags 0; out_hi tied 0; no MUL state logic.

## Structure
- Package fsm_alu_pkg: opcode enum (ADD…RSVD), state enum, OP_W=3 constant.
- Sub-module fsm_alu_mul: start/done iterative WIDTH×WIDTH unsigned multiplier, instantiated only under FSM_ALU_MUL_EN.

## Test plan
- WIDTH=8, ADD 5+2 → out_s=0x07, carry=0, ovf=0, zero=0, out_valid at N+1.
- SUB 2−5 → out_s=0xFD, carry=1, ovf=0; SUB 0x80−0x01 → 0x7F, ovf=1.
- ADD 0xFF+0x01 → out_s=0x00, carry=1, zero=1; ADD 0x7F+0x01 → 0x80, ovf=1.
- out_ready held low 5 cycles in DONE → out_valid and out_s stable, in_ready=0, new in_valid not accepted; release → IDLE next cycle.
- MUL 0x12×0x34 → out_s=0xA8, out_hi=0x03, out_valid at N+8 (macro on); macro off → out_err=1, out_s=0 at N+1; op 7 → out_err=1 in both builds.
- sys_rst_n low 2 cycles mid-MUL → all outputs 0 immediately, in_ready=1 after release, next ADD 1+1 → 0x02.
